// File: rtl/upack_pkg.sv
// Shared types and helpers for the packed-to-lane scatter block.
package upack_pkg;

  localparam int NUM_LANES = 4;
  localparam int SAMPLE_W  = 16;
  localparam int BUF_SLOTS = 8;

  typedef logic [1:0] lane_idx_t;
  typedef logic [2:0] count_t;

  function automatic count_t popcount4(input logic [NUM_LANES-1:0] mask);
    return {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
  endfunction

endpackage

// File: rtl/upack_lane_scatter_if.sv
// Packed input stream, per-lane output stream and channel enable mask.
interface upack_lane_scatter_if;
  import upack_pkg::*;

  logic [NUM_LANES-1:0]          enable;
  logic [NUM_LANES*SAMPLE_W-1:0] s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic [NUM_LANES*SAMPLE_W-1:0] m_data;
  logic                          m_valid;
  logic                          m_ready;
  logic [NUM_LANES-1:0]          m_enable;

  modport master (
    output enable, s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_enable
  );

  modport slave (
    input  enable, s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_enable
  );

endinterface

// File: rtl/upack_lane_scatter_lane_map.sv
// Enable mask to per-lane buffer slot: the k-th set bit of the mask reads slot k.
module enable_to_lane_map
  import upack_pkg::*;
(
  input  logic [NUM_LANES-1:0]            mask,
  output lane_idx_t [NUM_LANES-1:0]       slot,
  output logic [NUM_LANES-1:0]            lane_valid
);

  always_comb begin
    logic [2:0] acc;
    acc        = '0;
    slot       = '0;
    lane_valid = mask;
    for (int i = 0; i < NUM_LANES; i++) begin
      slot[i] = acc[1:0];
      acc     = acc + {2'b00, mask[i]};
    end
  end

endmodule

// File: rtl/upack_lane_scatter.sv
// Scatters a packed stream of enabled-channel samples back onto fixed per-channel lanes,
// carrying leftover samples across input words in an 8-slot sample buffer.
module upack_lane_scatter
  import upack_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  upack_lane_scatter_if.slave  bus
);

  logic [NUM_LANES-1:0] enable_q;
  count_t               count;
  logic [SAMPLE_W-1:0]  buffer   [BUF_SLOTS];
  logic [SAMPLE_W-1:0]  buf_next [BUF_SLOTS];
  count_t               count_next;
  count_t               n;
  count_t               base;
  logic                 out_fire;
  logic                 in_fire;
  logic                 flush;
  logic                 m_valid_c;
  logic                 s_ready_c;
  logic [NUM_LANES*SAMPLE_W-1:0] m_data_c;
  lane_idx_t [NUM_LANES-1:0]     slot;
  logic [NUM_LANES-1:0]          lane_valid;

  enable_to_lane_map u_map (
    .mask       (enable_q),
    .slot       (slot),
    .lane_valid (lane_valid)
  );

  assign n         = popcount4(enable_q);
  assign m_valid_c = (n != 3'd0) && (count >= n);
  // Accept also when this cycle's output pop frees enough room for a whole word.
  assign s_ready_c = (count <= 3'd3) ||
                     (bus.m_ready && (n != 3'd0) && (count >= n) && ((count - n) <= 3'd3));
  assign in_fire   = bus.s_valid && s_ready_c;
  assign out_fire  = m_valid_c && bus.m_ready;
  assign flush     = (bus.enable != enable_q);
  assign base      = out_fire ? (count - n) : count;

  always_comb begin
    logic [3:0] src;
    logic [2:0] dst;
    src = '0;
    dst = '0;
    for (int i = 0; i < BUF_SLOTS; i++) begin
      buf_next[i] = buffer[i];
    end
    if (out_fire) begin
      for (int i = 0; i < BUF_SLOTS; i++) begin
        src = 4'(i) + {1'b0, n};
        buf_next[i] = src[3] ? '0 : buffer[src[2:0]];
      end
    end
    if (in_fire && (n != 3'd0)) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        dst = base + 3'(j);
        buf_next[dst] = bus.s_data[j*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Words arriving while no channel is enabled are consumed and dropped.
  always_comb begin
    count_next = base;
    if (in_fire && (n != 3'd0)) begin
      count_next = base + 3'd4;
    end
    if (flush) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      count    <= '0;
      for (int i = 0; i < BUF_SLOTS; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      enable_q <= bus.enable;
      count    <= count_next;
      for (int i = 0; i < BUF_SLOTS; i++) begin
        buffer[i] <= buf_next[i];
      end
    end
  end

  always_comb begin
    m_data_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_valid[i]) begin
        m_data_c[i*SAMPLE_W +: SAMPLE_W] = buffer[{1'b0, slot[i]}];
      end
    end
  end

  assign bus.m_data   = m_data_c;
  assign bus.m_valid  = m_valid_c;
  assign bus.m_enable = enable_q;
  assign bus.s_ready  = s_ready_c;

endmodule
